// File: rtl/act_window_stream_pkg.sv
// act_pkg: shared types and constants for the activation window stream.
// Provides the activation element type, the row FSM state encoding and the
// zero-padding column count helper.
package act_pkg;
   localparam int ACT_DW = 16;
   localparam int ACT_K = 3;
   typedef logic [ACT_DW-1:0] act_t;
   typedef enum logic [1:0] {FILL, STREAM, PAD} state_t;
   function automatic int pad_cols(input int k);
      return (k - 1) / 2;
   endfunction
   localparam int PAD_COLS = pad_cols(ACT_K);
endpackage

// File: rtl/act_window_stream_shift_ch.sv
// act_window_shift_ch: one channel's KxK window held as K column registers.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_shift    : shift the window one column left and load i_col into column K-1
//   i_clr      : with i_shift, zero every older column instead of shifting it
//   i_col      : incoming column, row 0 at the MSB
//   o_win      : window, element r*K+c MSB-first, c=0 the oldest column
module act_window_shift_ch
   import act_pkg::*;
#(
   parameter int DW = 16,
   parameter int K = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_shift,
   input  logic            i_clr,
   input  logic [DW*K-1:0] i_col,
   output logic [DW*K*K-1:0] o_win
);
   logic [DW*K-1:0] r_col [K];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '{default: '0};
      end else if (i_shift) begin
         for (int c = 0; c < K - 1; c++) r_col[c] <= i_clr ? '0 : r_col[c+1];
         r_col[K-1] <= i_col;
      end
   end
   for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
         assign o_win[DW*(K*K-(r*K+c))-1 -: DW] = r_col[c][DW*(K-r)-1 -: DW];
      end
   end
endmodule

// File: rtl/act_window_stream.sv
// act_window_stream: streams KxK activation windows per channel from columns.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   col_valid/col_ready   : column handshake; col_data holds K rows per channel
//   col_last              : column is the last of the image row
//   win_valid/win_ready   : window handshake; win_data is the window registers
//   win_last              : window is the last of the row
// Define ACT_WIN_ZERO_PAD_EN to add (K-1)/2 zero columns at both row edges.
module act_window_stream
   import act_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int CH = 64,
   parameter int K = 3,
   parameter int STRIDE = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         col_valid,
   output logic                         col_ready,
   input  logic [DATA_WIDTH*K*CH-1:0]   col_data,
   input  logic                         col_last,
   output logic                         win_valid,
   input  logic                         win_ready,
   output logic [DATA_WIDTH*K*K*CH-1:0] win_data,
   output logic                         win_last
);
   localparam int CW = ($clog2(K + 1) < 1) ? 1 : $clog2(K + 1);
   localparam int PW = ($clog2(STRIDE) < 1) ? 1 : $clog2(STRIDE);
`ifdef ACT_WIN_ZERO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif
   localparam int P = PAD_EN ? pad_cols(K) : 0;
   localparam bit HAS_PAD = (P != 0);
   localparam logic [CW-1:0] CK = CW'(K);
   localparam logic [CW-1:0] CP = CW'(P);
   localparam logic [PW-1:0] PH_MAX = PW'(STRIDE - 1);
   state_t r_st, w_st_nx;
   logic [CW-1:0] r_cnt, r_pc, w_cnt_nx;
   logic [PW-1:0] r_ph;
   logic r_wv, r_wl;
   logic w_free, w_acc, w_pad_sh, w_sh, w_cand, w_emit, w_to_pad, w_row_done, w_clr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_st <= FILL;
      else r_st <= w_st_nx;
   end
   always_comb begin
      w_st_nx = r_st;
      if (w_row_done) w_st_nx = FILL;
      else if (w_to_pad) w_st_nx = PAD;
      else if (r_st == FILL && w_sh && w_cnt_nx == CK) w_st_nx = STREAM;
   end
   // Shifts happen only when the output slot is free, so a held window is
   // never overwritten; pad columns are injected internally while input stalls.
   always_comb begin
      w_free = !r_wv || win_ready;
      col_ready = (r_st != PAD) && w_free;
      w_acc = col_valid && col_ready;
      w_pad_sh = (r_st == PAD) && w_free;
      w_sh = w_acc || w_pad_sh;
      w_cnt_nx = (r_cnt == CK) ? CK : r_cnt + 1'b1;
      w_cand = w_sh && (w_cnt_nx == CK);
      w_emit = w_cand && (r_ph == '0);
      w_to_pad = w_acc && col_last && HAS_PAD;
      w_row_done = (w_acc && col_last && !HAS_PAD) || (w_pad_sh && r_pc == CW'(1));
      // First column of a padded row wipes the previous row's leftovers.
      w_clr = PAD_EN && (r_st == FILL) && (r_cnt == CP);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= CP;
         r_ph <= '0;
         r_pc <= '0;
         r_wv <= 1'b0;
         r_wl <= 1'b0;
      end else begin
         r_cnt <= w_row_done ? CP : w_sh ? w_cnt_nx : r_cnt;
         r_ph <= w_row_done ? '0 : w_cand ? ((r_ph == PH_MAX) ? '0 : r_ph + 1'b1) : r_ph;
         r_pc <= w_to_pad ? CP : w_pad_sh ? r_pc - 1'b1 : r_pc;
         r_wv <= w_emit || (r_wv && !win_ready);
         r_wl <= w_emit ? w_row_done : (r_wl && !win_ready);
      end
   end
   assign win_valid = r_wv;
   assign win_last = r_wl;
   for (genvar i = 0; i < CH; i++) begin : g_ch
      act_window_shift_ch #(.DW(DATA_WIDTH), .K(K)) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_shift(w_sh),
         .i_clr  (w_clr),
         .i_col  (w_pad_sh ? '0 : col_data[DATA_WIDTH*K*(CH-i)-1 -: DATA_WIDTH*K]),
         .o_win  (win_data[DATA_WIDTH*K*K*(CH-i)-1 -: DATA_WIDTH*K*K])
      );
   end
endmodule

// File: tb/tb_act_window_stream.sv
// tb_act_window_stream: directed self-checking bench for act_window_stream.
module tb_act_window_stream;
   localparam int DW = 16;
   localparam int K = 3;
   localparam int CH = 2;
   localparam int CWD = DW * K * CH;
   localparam int WWD = DW * K * K * CH;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic col_valid = 1'b0;
   logic col_last = 1'b0;
   logic win_ready = 1'b1;
   logic [CWD-1:0] col_data = '0;
   logic a_cr, a_wv, a_wl, b_cr, b_wv, b_wl;
   logic [WWD-1:0] a_wd, b_wd;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   act_window_stream #(.DATA_WIDTH(DW), .CH(CH), .K(K), .STRIDE(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .col_valid(col_valid), .col_ready(a_cr),
      .col_data(col_data), .col_last(col_last), .win_valid(a_wv),
      .win_ready(win_ready), .win_data(a_wd), .win_last(a_wl));
   act_window_stream #(.DATA_WIDTH(DW), .CH(CH), .K(K), .STRIDE(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .col_valid(col_valid), .col_ready(b_cr),
      .col_data(col_data), .col_last(col_last), .win_valid(b_wv),
      .win_ready(win_ready), .win_data(b_wd), .win_last(b_wl));

   function automatic logic [DW-1:0] val(input int ch, input int c, input int r);
      return (c < 0) ? '0 : DW'(ch * 1000 + 100 * c + r);
   endfunction

   function automatic logic [CWD-1:0] mk_col(input int n);
      logic [CWD-1:0] d;
      d = '0;
      for (int ch = 0; ch < CH; ch++)
         for (int r = 0; r < K; r++) d[CWD-DW*K*ch-DW*r-1 -: DW] = val(ch, n, r);
      return d;
   endfunction

   function automatic logic [WWD-1:0] mk_win(input int c0, input int c1, input int c2);
      logic [WWD-1:0] w;
      int cs [3];
      cs = '{c0, c1, c2};
      w = '0;
      for (int ch = 0; ch < CH; ch++)
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) w[WWD-DW*K*K*ch-DW*(r*K+c)-1 -: DW] = val(ch, cs[c], r);
      return w;
   endfunction

   task automatic drive_col(input int n, input bit last);
      col_valid = 1'b1;
      col_data = mk_col(n);
      col_last = last;
      @(posedge clk);
      #1;
      col_valid = 1'b0;
      col_last = 1'b0;
   endtask

   task automatic apply_reset;
      col_valid = 1'b0;
      col_last = 1'b0;
      win_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (a_wv !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%b want=0", a_wv); end
      checks++; if (a_wl !== 1'b0) begin failures++; $display("FAIL reset_win_last got=%b want=0", a_wl); end
      checks++; if (a_wd !== '0) begin failures++; $display("FAIL reset_win_data got=%h want=0", a_wd); end
      checks++; if (a_cr !== 1'b1) begin failures++; $display("FAIL reset_col_ready got=%b want=1", a_cr); end
      checks++; if (b_wv !== 1'b0) begin failures++; $display("FAIL reset_s2_win_valid got=%b want=0", b_wv); end
      rst_n = 1'b1;
   endtask

`ifndef ACT_WIN_ZERO_PAD_EN
   task automatic test_stream;
      apply_reset();
      for (int n = 0; n < 5; n++) begin
         drive_col(n, n == 4);
         checks++; if (a_wv !== (n >= 2)) begin failures++; $display("FAIL stream_valid col=%0d got=%b want=%b", n, a_wv, n >= 2); end
         checks++; if (a_wl !== (n == 4)) begin failures++; $display("FAIL stream_last col=%0d got=%b want=%b", n, a_wl, n == 4); end
         if (n >= 2) begin
            checks++; if (a_wd !== mk_win(n-2, n-1, n)) begin failures++; $display("FAIL stream_data col=%0d got=%h want=%h", n, a_wd, mk_win(n-2, n-1, n)); end
         end
         if (n == 2) begin
            checks++; if (a_wd[WWD-1 -: DW*K*K] !== 144'h0000_0064_00c8_0001_0065_00c9_0002_0066_00ca) begin failures++; $display("FAIL stream_win0_ch0 got=%h", a_wd[WWD-1 -: DW*K*K]); end
         end
      end
      @(posedge clk);
      #1;
      checks++; if (a_wv !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b want=0", a_wv); end
   endtask

   task automatic test_stride;
      apply_reset();
      for (int n = 0; n < 5; n++) begin
         drive_col(n, n == 4);
         checks++; if (b_wv !== (n == 2 || n == 4)) begin failures++; $display("FAIL stride_valid col=%0d got=%b want=%b", n, b_wv, n == 2 || n == 4); end
         checks++; if (b_wl !== (n == 4)) begin failures++; $display("FAIL stride_last col=%0d got=%b want=%b", n, b_wl, n == 4); end
         if (n == 2 || n == 4) begin
            checks++; if (b_wd !== mk_win(n-2, n-1, n)) begin failures++; $display("FAIL stride_data col=%0d got=%h want=%h", n, b_wd, mk_win(n-2, n-1, n)); end
         end
      end
   endtask

   task automatic test_backpressure;
      apply_reset();
      for (int n = 0; n < 3; n++) drive_col(n, 1'b0);
      checks++; if (a_wv !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=%b want=1", a_wv); end
      win_ready = 1'b0;
      col_valid = 1'b1;
      col_data = mk_col(3);
      #1;
      checks++; if (a_cr !== 1'b0) begin failures++; $display("FAIL bp_col_ready got=%b want=0", a_cr); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++; if (a_wv !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", i, a_wv); end
         checks++; if (a_wd !== mk_win(0, 1, 2)) begin failures++; $display("FAIL bp_hold_data cyc=%0d got=%h want=%h", i, a_wd, mk_win(0, 1, 2)); end
         checks++; if (a_cr !== 1'b0) begin failures++; $display("FAIL bp_hold_ready cyc=%0d got=%b want=0", i, a_cr); end
      end
      win_ready = 1'b1;
      #1;
      checks++; if (a_cr !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", a_cr); end
      @(posedge clk);
      #1;
      col_valid = 1'b0;
      checks++; if (a_wv !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%b want=1", a_wv); end
      checks++; if (a_wd !== mk_win(1, 2, 3)) begin failures++; $display("FAIL bp_next_data got=%h want=%h", a_wd, mk_win(1, 2, 3)); end
      @(posedge clk);
      #1;
      checks++; if (a_wv !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", a_wv); end
   endtask

   task automatic test_short_row;
      apply_reset();
      drive_col(0, 1'b0);
      drive_col(1, 1'b1);
      checks++; if (a_wv !== 1'b0 || a_wl !== 1'b0) begin failures++; $display("FAIL short_row_none got=%b%b want=00", a_wv, a_wl); end
      for (int n = 5; n < 8; n++) begin
         drive_col(n, n == 7);
         checks++; if (a_wv !== (n == 7)) begin failures++; $display("FAIL short_next_valid col=%0d got=%b want=%b", n, a_wv, n == 7); end
      end
      checks++; if (a_wd !== mk_win(5, 6, 7)) begin failures++; $display("FAIL short_next_data got=%h want=%h", a_wd, mk_win(5, 6, 7)); end
      checks++; if (a_wl !== 1'b1) begin failures++; $display("FAIL short_next_last got=%b want=1", a_wl); end
   endtask

   task automatic test_midrow_reset;
      apply_reset();
      for (int n = 0; n < 3; n++) drive_col(n, 1'b0);
      checks++; if (a_wv !== 1'b1) begin failures++; $display("FAIL mr_pending got=%b want=1", a_wv); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (a_wv !== 1'b0) begin failures++; $display("FAIL mr_async_valid got=%b want=0", a_wv); end
      checks++; if (a_wd !== '0) begin failures++; $display("FAIL mr_async_data got=%h want=0", a_wd); end
      rst_n = 1'b1;
      for (int n = 10; n < 13; n++) begin
         drive_col(n, 1'b0);
         checks++; if (a_wv !== (n == 12)) begin failures++; $display("FAIL mr_refill_valid col=%0d got=%b want=%b", n, a_wv, n == 12); end
      end
      checks++; if (a_wd !== mk_win(10, 11, 12)) begin failures++; $display("FAIL mr_refill_data got=%h want=%h", a_wd, mk_win(10, 11, 12)); end
   endtask
`else
   task automatic test_zero_pad;
      apply_reset();
      drive_col(0, 1'b0);
      checks++; if (a_wv !== 1'b0) begin failures++; $display("FAIL pad_first_valid got=%b want=0", a_wv); end
      for (int n = 1; n < 4; n++) begin
         drive_col(n, n == 3);
         checks++; if (a_wv !== 1'b1) begin failures++; $display("FAIL pad_valid col=%0d got=%b want=1", n, a_wv); end
         checks++; if (a_wd !== mk_win(n-2, n-1, n)) begin failures++; $display("FAIL pad_data col=%0d got=%h want=%h", n, a_wd, mk_win(n-2, n-1, n)); end
         checks++; if (a_wl !== 1'b0) begin failures++; $display("FAIL pad_last col=%0d got=%b want=0", n, a_wl); end
      end
      checks++; if (a_cr !== 1'b0) begin failures++; $display("FAIL pad_ready_low got=%b want=0", a_cr); end
      @(posedge clk);
      #1;
      checks++; if (a_wv !== 1'b1) begin failures++; $display("FAIL pad_tail_valid got=%b want=1", a_wv); end
      checks++; if (a_wd !== mk_win(2, 3, -1)) begin failures++; $display("FAIL pad_tail_data got=%h want=%h", a_wd, mk_win(2, 3, -1)); end
      checks++; if (a_wl !== 1'b1) begin failures++; $display("FAIL pad_tail_last got=%b want=1", a_wl); end
      checks++; if (a_cr !== 1'b1) begin failures++; $display("FAIL pad_ready_back got=%b want=1", a_cr); end
      @(posedge clk);
      #1;
      checks++; if (a_wv !== 1'b0) begin failures++; $display("FAIL pad_drain got=%b want=0", a_wv); end
   endtask
`endif

   initial begin
      test_reset();
`ifndef ACT_WIN_ZERO_PAD_EN
      test_stream();
      test_stride();
      test_backpressure();
      test_short_row();
      test_midrow_reset();
`else
      test_zero_pad();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
